// File: rtl/spm_banked_dp.sv
`timescale 1ns/1ps
// spm_banked_dp: word-interleaved scratchpad shared by the CPU data port and
// the SPM DMA engine. Each bank is single-ported with byte-lane writes. When
// both ports hit the same bank the CPU wins, unless the DMA has already lost
// starveLimit cycles in a row, in which case the DMA wins and the CPU stalls.
//
// Ports:
//   clock, reset          rising-edge clock, asynchronous active-high reset
//   spmCs/spmWe/spmAddress/spmByteEnables/dataToSpm
//                         CPU request (word address), held while spmStall=1
//   dataFromSpm           CPU read data, registered, held between reads
//   spmStall              CPU request not accepted this cycle (combinational)
//   dmaReq/dmaWe/dmaAddress/dmaByteEnables/dmaWriteData
//                         DMA request (byte address), held until dmaAck
//   dmaAck                DMA request accepted this cycle (combinational)
//   dmaReadData/dmaReadValid
//                         DMA read data, registered; valid pulses one cycle
//   conflictClear         synchronous clear of conflictCount
//   conflictCount         saturating count of same-bank conflict cycles
module spm_banked_dp #(
    parameter int unsigned sizeInBytes = 2048,
    parameter int unsigned nrOfBanks   = 2,
    parameter int unsigned starveLimit = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        spmCs,
    input  logic        spmWe,
    input  logic [17:0] spmAddress,
    input  logic [3:0]  spmByteEnables,
    input  logic [31:0] dataToSpm,
    output logic [31:0] dataFromSpm,
    output logic        spmStall,
    input  logic        dmaReq,
    input  logic        dmaWe,
    input  logic [31:0] dmaAddress,
    input  logic [3:0]  dmaByteEnables,
    input  logic [31:0] dmaWriteData,
    output logic        dmaAck,
    output logic [31:0] dmaReadData,
    output logic        dmaReadValid,
    input  logic        conflictClear,
    output logic [15:0] conflictCount
);
    localparam int unsigned wordCount = sizeInBytes / 4;
    localparam int unsigned addrBits  = $clog2(wordCount);
    localparam int unsigned bankBits  = $clog2(nrOfBanks);
    localparam int unsigned bankW     = (bankBits == 0) ? 1 : bankBits;
    localparam int unsigned rowBits   = addrBits - bankBits;
    localparam int unsigned bankDepth = wordCount / nrOfBanks;

    logic [addrBits-1:0] cpuWa, dmaWa;
    logic [bankW-1:0]    cpuBank, dmaBank;
    logic [rowBits-1:0]  cpuRow, dmaRow;
    logic                sameBank, dmaWins, cpuGrant, dmaGrant;
    logic [3:0]          starveCnt;

    logic [nrOfBanks-1:0]               bankEn, bankWe;
    logic [nrOfBanks-1:0][rowBits-1:0]  bankRow;
    logic [nrOfBanks-1:0][31:0]         bankWd, bankRd;
    logic [nrOfBanks-1:0][3:0]          bankBe;
    logic [31:0]                        cpuRd, dmaRd;

    // Out-of-range addresses alias by dropping the upper bits.
    assign cpuWa = spmAddress[addrBits-1:0];
    assign dmaWa = dmaAddress[addrBits+1:2];

    logic unusedBits;
    assign unusedBits = &{1'b0, spmAddress[17:addrBits], dmaAddress[31:addrBits+2], dmaAddress[1:0]};

    // Low word-address bits pick the bank, the rest pick the row.
    if (bankBits == 0) begin : gSingle
        assign cpuBank = '0;
        assign dmaBank = '0;
        assign cpuRow  = cpuWa;
        assign dmaRow  = dmaWa;
    end else begin : gMulti
        assign cpuBank = cpuWa[bankBits-1:0];
        assign dmaBank = dmaWa[bankBits-1:0];
        assign cpuRow  = cpuWa[addrBits-1:bankBits];
        assign dmaRow  = dmaWa[addrBits-1:bankBits];
    end

    // Arbitration: CPU priority on a shared bank unless the DMA is starving.
    always_comb begin
        sameBank = spmCs && dmaReq && (cpuBank == dmaBank);
        dmaWins  = sameBank && (starveCnt == 4'(starveLimit));
        cpuGrant = !reset && spmCs && !dmaWins;
        dmaGrant = !reset && dmaReq && (!sameBank || dmaWins);
    end

    assign spmStall = !reset && dmaWins;
    assign dmaAck   = dmaGrant;

    // Route each granted port to its bank; the arbiter never grants both onto one bank.
    always_comb begin
        bankEn  = '0;
        bankWe  = '0;
        bankRow = '0;
        bankWd  = '0;
        bankBe  = '0;
        for (int b = 0; b < int'(nrOfBanks); b++) begin
            if (cpuGrant && (cpuBank == bankW'(b))) begin
                bankEn[b]  = 1'b1;
                bankWe[b]  = spmWe;
                bankRow[b] = cpuRow;
                bankWd[b]  = dataToSpm;
                bankBe[b]  = spmByteEnables;
            end else if (dmaGrant && (dmaBank == bankW'(b))) begin
                bankEn[b]  = 1'b1;
                bankWe[b]  = dmaWe;
                bankRow[b] = dmaRow;
                bankWd[b]  = dmaWriteData;
                bankBe[b]  = dmaByteEnables;
            end
        end
    end

    // One byte-writable single-port array per bank; contents survive reset.
    for (genvar b = 0; b < nrOfBanks; b++) begin : gBank
        logic [31:0] mem [bankDepth];

        always_ff @(posedge clock) begin
            if (bankEn[b] && bankWe[b]) begin
                for (int i = 0; i < 4; i++) begin
                    if (bankBe[b][i]) begin
                        mem[bankRow[b]][8*i +: 8] <= bankWd[b][8*i +: 8];
                    end
                end
            end
        end

        assign bankRd[b] = mem[bankRow[b]];
    end

    // Per-port read data select.
    always_comb begin
        cpuRd = '0;
        dmaRd = '0;
        for (int b = 0; b < int'(nrOfBanks); b++) begin
            if (cpuBank == bankW'(b)) cpuRd = bankRd[b];
            if (dmaBank == bankW'(b)) dmaRd = bankRd[b];
        end
    end

    // Registered read data, DMA valid pulse, starvation and conflict counters.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            dataFromSpm   <= '0;
            dmaReadData   <= '0;
            dmaReadValid  <= 1'b0;
            starveCnt     <= '0;
            conflictCount <= '0;
        end else begin
            if (cpuGrant && !spmWe) dataFromSpm <= cpuRd;
            if (dmaGrant && !dmaWe) dmaReadData <= dmaRd;
            dmaReadValid <= dmaGrant && !dmaWe;

            if (!dmaReq || dmaGrant) begin
                starveCnt <= '0;
            end else if (sameBank) begin
                starveCnt <= starveCnt + 4'd1;
            end

            if (conflictClear) begin
                conflictCount <= '0;
            end else if (sameBank && (conflictCount != 16'hFFFF)) begin
                conflictCount <= conflictCount + 16'd1;
            end
        end
    end
endmodule

// File: doc/spm_banked_dp.md
Name: spm_banked_dp

Overview:
Parametrised scratchpad memory, the next generation after the fixed 2 KiB SPM. It is word-interleaved into NUM_BANKS single-port banks with byte-enable writes on both the CPU and the DMA side. Per-bank arbitration uses a starvation guard, and a CPU stall output covers cycles where the CPU loses a bank. It sits between the CPU data port and the SPM DMA engine.

Parameters:
sizeInBytes, 2048, total capacity; power of two, 256..65536
nrOfBanks, 2, number of word-interleaved banks; power of two, 1..8
starveLimit, 4, consecutive DMA losses before DMA is forced to win; 1..15

Ports:
clock  in  1  system clock, all state on rising edge
reset  in  1  asynchronous, active-high
spmCs  in  1  CPU access request
spmWe  in  1  CPU write (1) / read (0)
spmAddress  in  18  CPU word address; low log2(sizeInBytes/4) bits used
spmByteEnables  in  4  CPU byte lanes for writes
dataToSpm  in  32  CPU write data
dataFromSpm  out  32  CPU read data, registered
spmStall  out  1  CPU request not accepted this cycle; hold request stable
dmaReq  in  1  DMA access request
dmaWe  in  1  DMA write (1) / read (0)
dmaAddress  in  32  DMA byte address; bits [1:0] ignored
dmaByteEnables  in  4  DMA byte lanes for writes
dmaWriteData  in  32  DMA write data
dmaAck  out  1  DMA request accepted this cycle (combinational)
dmaReadData  out  32  DMA read data, registered
dmaReadValid  out  1  dmaReadData valid, one-cycle pulse
conflictClear  in  1  synchronous clear of conflictCount
conflictCount  out  16  saturating count of same-bank conflict cycles

Behaviour:
- Word address: wa = addr mod (sizeInBytes/4). Out-of-range addresses alias by wrap-around and raise no error.
- Bank select: bank = wa[log2(nrOfBanks)-1:0]. Row within bank = remaining upper bits. nrOfBanks=1: every simultaneous request conflicts.
- Byte lanes: only enabled lanes are written; disabled lanes keep their contents. Reads ignore byte enables and return the full word.
- Per-cycle arbitration (combinational):
  - Only one requester, or both on different banks: all requesters granted; spmStall=0; dmaAck=dmaReq.
  - Both on the same bank, starveCnt<starveLimit: CPU granted; spmStall=0; dmaAck=0; starveCnt+1.
  - Both on the same bank, starveCnt==starveLimit: DMA granted; dmaAck=1; spmStall=1; starveCnt to 0.
- starveCnt: 4-bit register. Cleared on any DMA grant and on any cycle with dmaReq=0. It never exceeds starveLimit.
- Latency:
  - Granted read in cycle N: data on dataFromSpm / dmaReadData at cycle N+1 and held until the next granted read on that port.
  - dmaReadValid=1 only in cycle N+1.
  - Writes complete at the edge ending cycle N; a read granted in N+1 returns the new data.
- Same port, same cycle, read and write are impossible (single spmWe / dmaWe). Cross-port same-address access is impossible, because same address implies same bank, so it is serialised.
- conflictCount increments once per same-bank conflict cycle and saturates at 16'hFFFF. If conflictClear and a conflict occur in the same cycle, clear wins and the result is 0.
- Stall protocol: while spmStall=1 the CPU holds spmCs, spmWe, spmAddress, spmByteEnables and dataToSpm. DMA holds its request until dmaAck.
- Reset (asynchronous, any time, including mid-access):
  - Outputs: dataFromSpm=0, dmaReadData=0, dmaReadValid=0, conflictCount=0.
  - Internal state: starveCnt=0, pending-read flags=0.
  - spmStall and dmaAck follow the combinational inputs but are forced 0 during reset.
  - Memory contents are not cleared. Any in-flight read is discarded.
- Storage: one inferred single-port RAM per bank, depth sizeInBytes/(4*nrOfBanks), with byte-write enables.

Test Plan:
- Default params. CPU writes 0xDEADBEEF to word 5, be=4'hF, then writes 0x000000AA to word 5 with be=4'h1. CPU read of word 5 -> dataFromSpm=0xDEADBEAA one cycle after request.
- CPU reads word 2 (bank 0) while DMA writes 0x12345678 at byte 0x0C (word 3, bank 1) in the same cycle -> spmStall=0, dmaAck=1, conflictCount stays 0.
- CPU continuously reads bank 0 while DMA requests word 4 (bank 0), starveLimit=4 -> dmaAck low for 4 cycles, high in cycle 5 with spmStall=1, conflictCount=5.
- DMA reads byte address 0x800 (wraps to word 0) after CPU wrote 0xCAFEF00D to word 0 -> dmaReadValid pulses one cycle later with dmaReadData=0xCAFEF00D.
- Preload conflictCount to 0xFFFF, run further conflicts -> count holds 0xFFFF. Assert conflictClear during a conflict cycle -> count reads 0.
- Assert reset in the cycle after a granted CPU read -> dataFromSpm=0, no dmaReadValid. After reset, re-reading the same word returns its pre-reset contents.
- nrOfBanks=1, sizeInBytes=256: simultaneous CPU and DMA requests to words 0 and 1 -> conflict every cycle, and DMA wins once per starveLimit+1 cycles.
